// File: rtl/grant_seq_pkg.sv
// rtl/grant_seq_pkg.sv - shared state encoding and width helpers for the grant sequencer
package grant_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Index width used by the upstream encoder stages and by this block.
  function automatic int idx_width(input int inputs);
    return $clog2(inputs);
  endfunction

  function automatic int cnt_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/popcount_sat.sv
// rtl/popcount_sat.sv - population count of the request vector, saturated at STAGES
module popcount_sat #(
  parameter int INPUTS = 12,
  parameter int STAGES = 7,
  parameter int CNT_W  = 3
) (
  input  logic [INPUTS-1:0] req,
  output logic [CNT_W-1:0]  count
);

  int sum;

  always_comb begin
    sum = 0;
    for (int i = 0; i < INPUTS; i++) begin
      sum = sum + int'(req[i]);
    end
    count = (sum > STAGES) ? CNT_W'(STAGES) : CNT_W'(sum);
  end

endmodule

// File: rtl/grant_sequencer.sv
// rtl/grant_sequencer.sv - replays encoder indices one per handshake; GRANT_SEQ_ONEHOT_EN adds grant_onehot
module grant_sequencer
  import grant_seq_pkg::*;
#(
  parameter int INPUTS = 12,
  parameter int STAGES = 7,
  localparam int WIDTH_OUT = idx_width(INPUTS),
  localparam int CNT_W     = cnt_width(STAGES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [INPUTS-1:0]             req,
  input  logic [WIDTH_OUT*STAGES-1:0]   idx_in,
  input  logic                          load_valid,
  output logic                          load_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH_OUT-1:0]          out_index,
  output logic                          out_last,
  output logic                          done,
`ifdef GRANT_SEQ_ONEHOT_EN
  output logic [INPUTS-1:0]             grant_onehot,
`endif
  input  logic                          flush
);

  state_t                        state;
  logic [CNT_W-1:0]              ptr;
  logic [CNT_W-1:0]              count;
  logic [WIDTH_OUT*STAGES-1:0]   idx_q;
  logic [CNT_W-1:0]              load_count;
  logic                          is_last;

  popcount_sat #(
    .INPUTS (INPUTS),
    .STAGES (STAGES),
    .CNT_W  (CNT_W)
  ) u_popcount_sat (
    .req   (req),
    .count (load_count)
  );

  assign load_ready = (state == IDLE);
  assign is_last    = (ptr == (count - CNT_W'(1)));
  assign out_valid  = (state == EMIT);
  assign out_last   = out_valid && is_last;
  assign out_index  = out_valid ? idx_q[int'(ptr)*WIDTH_OUT +: WIDTH_OUT] : '0;

`ifdef GRANT_SEQ_ONEHOT_EN
  assign grant_onehot = out_valid ? (INPUTS'(1) << out_index) : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      count <= '0;
      idx_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A flush in the same cycle cancels the offered load.
          if (load_valid && !flush) begin
            idx_q <= idx_in;
            count <= load_count;
            ptr   <= '0;
            if (load_count == '0) begin
              done <= 1'b1;
            end else begin
              state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (out_ready) begin
            if (is_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              ptr <= ptr + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grant_sequencer.sv
// tb/tb_grant_sequencer.sv - directed and randomized bench for grant_sequencer
module tb_grant_sequencer;

  localparam int INPUTS = 12;
  localparam int STAGES = 7;
  localparam int W      = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [INPUTS-1:0]     req;
  logic [W*STAGES-1:0]   idx_in;
  logic                  load_valid;
  logic                  load_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_index;
  logic                  out_last;
  logic                  done;
  logic                  flush;
`ifdef GRANT_SEQ_ONEHOT_EN
  logic [INPUTS-1:0]     grant_onehot;
`endif

  int checks = 0;
  int errors = 0;

  grant_sequencer #(.INPUTS(INPUTS), .STAGES(STAGES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .idx_in     (idx_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_last   (out_last),
    .done       (done),
`ifdef GRANT_SEQ_ONEHOT_EN
    .grant_onehot (grant_onehot),
`endif
    .flush      (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W*STAGES-1:0] pack3(input int a, input int b, input int c);
    logic [W*STAGES-1:0] v;
    v = '0;
    v[3:0]  = 4'(a);
    v[7:4]  = 4'(b);
    v[11:8] = 4'(c);
    return v;
  endfunction

  // stall_mode: 0 never stall, 1 random stalls, 2 three stall cycles on the third index
  task automatic run_batch(input logic [INPUTS-1:0] r, input logic [W*STAGES-1:0] ix, input int stall_mode);
    int exp_q[$];
    int n;
    int stalls;
    n = $countones(r);
    if (n > STAGES) n = STAGES;
    for (int k = 0; k < n; k++) exp_q.push_back(int'((ix >> (k*W)) & 'hF));

    check("load_ready_before_load", 32'(load_ready), 1);
    req = r; idx_in = ix; load_valid = 1'b1; out_ready = 1'b0;
    step();
    load_valid = 1'b0;
    req = $urandom; idx_in = {$urandom, $urandom};

    if (n == 0) begin
      check("empty_no_valid", 32'(out_valid), 0);
      check("empty_done", 32'(done), 1);
      check("empty_load_ready", 32'(load_ready), 1);
      return;
    end

    for (int k = 0; k < n; k++) begin
      if (stall_mode == 1) stalls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      else if (stall_mode == 2 && k == 2) stalls = 3;
      else stalls = 0;
      for (int s = 0; s <= stalls; s++) begin
        out_ready = (s == stalls);
        check("emit_valid", 32'(out_valid), 1);
        check("emit_index", 32'(out_index), 32'(exp_q[k]));
        check("emit_last", 32'(out_last), 32'(k == n-1));
        check("emit_no_done", 32'(done), 0);
        check("emit_not_ready", 32'(load_ready), 0);
`ifdef GRANT_SEQ_ONEHOT_EN
        check("emit_onehot", 32'(grant_onehot), 32'(1) << exp_q[k]);
`endif
        step();
      end
    end
    out_ready = 1'b0;
    check("batch_done", 32'(done), 1);
    check("batch_idle_valid", 32'(out_valid), 0);
    check("batch_idle_index", 32'(out_index), 0);
    check("batch_idle_last", 32'(out_last), 0);
    check("batch_load_ready", 32'(load_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; idx_in = '0; load_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    step();
    step();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_index", 32'(out_index), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    check("rst_release_ready", 32'(load_ready), 1);
    step();

    // Three-index batch, no backpressure, then an empty batch right in the done cycle
    run_batch(12'h025, pack3(0, 2, 5), 0);
    run_batch(12'h000, {$urandom, $urandom}, 0);
    step();
    check("empty_done_single", 32'(done), 0);
    check("empty_still_ready", 32'(load_ready), 1);

    // Saturated count and a stalled third index
    run_batch(12'hFFF, {4'h0, 4'hB, 4'h9, 4'h7, 4'h3, 4'hE, 4'h1}, 0);
    run_batch(12'h025, pack3(0, 2, 5), 2);
    step();
    check("idle_no_done", 32'(done), 0);

    // Flush during the second index of a three-index batch
    req = 12'h025; idx_in = pack3(0, 2, 5); load_valid = 1'b1;
    step();
    load_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("flush_pre_index", 32'(out_index), 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle", 32'(out_valid), 0);
    check("flush_no_done", 32'(done), 0);
    check("flush_ready", 32'(load_ready), 1);
    step();
    check("flush_no_done_late", 32'(done), 0);
    run_batch(12'h800, {$urandom, $urandom}, 0);

    // Flush in IDLE cancels a simultaneous load
    req = 12'h0F0; idx_in = pack3(3, 4, 5); load_valid = 1'b1; flush = 1'b1;
    check("flush_idle_ready", 32'(load_ready), 1);
    step();
    load_valid = 1'b0; flush = 1'b0;
    check("flush_cancel_valid", 32'(out_valid), 0);
    check("flush_cancel_done", 32'(done), 0);

    // Asynchronous reset mid-batch
    req = 12'h025; idx_in = pack3(6, 7, 8); load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_index", 32'(out_index), 0);
    check("async_rst_last", 32'(out_last), 0);
    check("async_rst_done", 32'(done), 0);
    check("async_rst_ready", 32'(load_ready), 1);
`ifdef GRANT_SEQ_ONEHOT_EN
    check("async_rst_onehot", 32'(grant_onehot), 0);
`endif
    step();
    rst_n = 1'b1;
    check("post_rst_ready", 32'(load_ready), 1);
    step();
    check("post_rst_no_done", 32'(done), 0);
    check("post_rst_no_valid", 32'(out_valid), 0);

    // Randomized batches, chained back to back through the done cycle
    for (int b = 0; b < 60; b++) begin
      logic [INPUTS-1:0] r;
      logic [W*STAGES-1:0] ix;
      r  = 12'($urandom);
      if ($urandom_range(0, 5) == 0) r = '0;
      ix = {$urandom, $urandom};
      run_batch(r, ix, 1);
      if ($urandom_range(0, 1) == 0) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
